prime_scan_ctrl: RTL and testbench

Sequencer for the prime-scan datapath: ROM source, prime checker, result RAM, seven-segment display.
- Steps a ROM address counter and pulses the prime checker for each word.
- Writes each prime into consecutive RAM slots.
- After the last ROM word, cycles the display through the stored primes until the next go press.
- Replaces the ad-hoc FSM and separate prime/done counters with one controller owning every datapath control strobe.

---
 rtl/prime_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_prime_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/prime_scan_ctrl.sv
// prime_scan_ctrl: sequencer for the prime-scan datapath (ROM -> prime checker -> RAM -> display).
// Ports:
//   clk          system clock (divided slow clock in the top level)
//   clr          synchronous active-high reset
//   go_btn       start request level; its rising edge starts a scan
//   chk_done     prime checker finished
//   chk_prime    checker verdict, valid while chk_done=1
//   rom_addr     ROM address under test
//   chk_start    one-cycle start pulse to the checker
//   ram_we       RAM write enable, one cycle per prime
//   ram_addr     RAM write slot while scanning, read slot while displaying
//   disp_sel     display mux select (0 = ROM word, 1 = RAM word)
//   busy         high while a scan is in progress
//   prime_total  primes stored by the last or current scan
//   err          sticky checker-timeout flag
// Optional feature macro PRIME_TIMEOUT_EN: abort a WAIT after CHK_TIMEOUT cycles and set err.
module prime_scan_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DISP_HOLD   = 2,
    parameter int CHK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              go_btn,
    input  logic              chk_done,
    input  logic              chk_prime,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              chk_start,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              disp_sel,
    output logic              busy,
    output logic [ADDR_W:0]   prime_total,
    output logic              err
);
    localparam int HW = DISP_HOLD > 1 ? $clog2(DISP_HOLD) : 1;
    typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, NEXT, DISPLAY} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W:0] p_cnt_q, p_cnt_d;
    logic [ADDR_W-1:0] d_cnt_q, d_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic go_q;
    logic go_edge;
    assign go_edge = go_btn & ~go_q;
`ifdef PRIME_TIMEOUT_EN
    localparam int TW = $clog2(CHK_TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic err_q, err_d;
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^CHK_TIMEOUT;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            p_cnt_q    <= '0;
            d_cnt_q    <= '0;
            hold_q     <= '0;
            go_q       <= go_btn;
`ifdef PRIME_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            p_cnt_q    <= p_cnt_d;
            d_cnt_q    <= d_cnt_d;
            hold_q     <= hold_d;
            go_q       <= go_btn;
`ifdef PRIME_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
`endif
        end
    end
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        p_cnt_d    = p_cnt_q;
        d_cnt_d    = d_cnt_q;
        hold_d     = hold_q;
`ifdef PRIME_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE, DISPLAY: begin
                if (go_edge) begin
                    state_d    = START;
                    rom_addr_d = '0;
                    p_cnt_d    = '0;
`ifdef PRIME_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end else if (state_q == DISPLAY) begin
                    // Advance the shown slot every DISP_HOLD cycles, wrapping after the last stored prime.
                    if (hold_q == HW'(DISP_HOLD - 1)) begin
                        hold_d  = '0;
                        d_cnt_d = (p_cnt_q <= (ADDR_W+1)'(1) || {1'b0, d_cnt_q} == p_cnt_q - (ADDR_W+1)'(1))
                                  ? '0 : d_cnt_q + ADDR_W'(1);
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            START: begin
                state_d = WAIT;
`ifdef PRIME_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (chk_done) begin
                    state_d = chk_prime ? WRITE : NEXT;
`ifdef PRIME_TIMEOUT_EN
                end else if (to_cnt_q == TW'(CHK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
`endif
                end
            end
            WRITE: begin
                p_cnt_d = p_cnt_q + (ADDR_W+1)'(1);
                state_d = NEXT;
            end
            NEXT: begin
                if (rom_addr_q == '1) begin
                    state_d = DISPLAY;
                    d_cnt_d = '0;
                    hold_d  = '0;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign rom_addr    = rom_addr_q;
    assign chk_start   = state_q == START;
    assign ram_we      = state_q == WRITE;
    assign disp_sel    = state_q == DISPLAY;
    assign ram_addr    = disp_sel ? d_cnt_q : p_cnt_q[ADDR_W-1:0];
    assign busy        = !(state_q == IDLE || state_q == DISPLAY);
    assign prime_total = p_cnt_q;
endmodule

// File: tb/tb_prime_scan_ctrl.sv
// tb_prime_scan_ctrl: scoreboard bench for prime_scan_ctrl with a behavioural prime checker.
module tb_prime_scan_ctrl;
    localparam int AW = 4;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic go_btn = 1'b0;
    logic chk_done = 1'b0;
    logic chk_prime = 1'b0;
    logic [AW-1:0] rom_addr, ram_addr;
    logic chk_start, ram_we, disp_sel, busy, err;
    logic [AW:0] prime_total;
    always #5 clk = ~clk;
    prime_scan_ctrl #(.ADDR_W(AW), .DISP_HOLD(2), .CHK_TIMEOUT(8)) dut (
        .clk(clk), .clr(clr), .go_btn(go_btn), .chk_done(chk_done), .chk_prime(chk_prime),
        .rom_addr(rom_addr), .chk_start(chk_start), .ram_we(ram_we), .ram_addr(ram_addr),
        .disp_sel(disp_sel), .busy(busy), .prime_total(prime_total), .err(err)
    );
    int n_chk = 0;
    int n_err = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    typedef struct {int slot; int addr;} wr_t;
    wr_t sb[$];
    wr_t e;
    logic [15:0] prime_map = 16'h003F;
    int hang_addr = -1;
    bit spur = 1'b0;
    int cnt = 0;
    int slot = 0;
    int starts = 0;
    int wait3 = 0;
    // Checker model answers two cycles after each start pulse; monitor pops the scoreboard on writes.
    always @(negedge clk) begin
        if (ram_we) begin
            if (sb.size() == 0) check("ram_we_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check("wr_slot", 32'(ram_addr), e.slot);
                check("wr_rom", 32'(rom_addr), e.addr);
                check("wr_total", 32'(prime_total), e.slot);
            end
        end
        if (chk_start) starts++;
        if (rom_addr == 4'd3 && busy && !chk_start && !ram_we) wait3++;
        chk_done = 1'b0;
        chk_prime = 1'b0;
        if (clr) cnt = 0;
        else if (chk_start) begin
            cnt = 2;
            if (spur) begin
                chk_done = 1'b1;
                chk_prime = 1'b1;
            end
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && int'(rom_addr) != hang_addr) begin
                chk_done = 1'b1;
                chk_prime = prime_map[rom_addr];
                if (chk_prime) begin
                    sb.push_back('{slot, int'(rom_addr)});
                    slot++;
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic press();
        starts = 0;
        slot = 0;
        wait3 = 0;
        go_btn = 1'b1;
        tick();
        go_btn = 1'b0;
    endtask
    task automatic wait_disp();
        for (int i = 0; i < 3000 && !disp_sel; i++) tick();
        check("disp_reached", 32'(disp_sel), 1);
    endtask
    task automatic scan_result(input int p, input int exp_err);
        check("prime_total", 32'(prime_total), p);
        check("start_pulses", starts, 16);
        check("sb_empty", sb.size(), 0);
        check("busy_disp", 32'(busy), 0);
        check("err", 32'(err), exp_err);
        for (int i = 0; i < 2 * p + 4; i++) begin
            check("disp_addr", 32'(ram_addr), p <= 1 ? 0 : (i / 2) % p);
            tick();
        end
        check("disp_sel_held", 32'(disp_sel), 1);
    endtask
    initial begin
        repeat (3) tick();
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_chk_start", 32'(chk_start), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_disp_sel", 32'(disp_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_prime_total", 32'(prime_total), 0);
        check("rst_err", 32'(err), 0);
        clr = 1'b0;
        tick();
        check("idle_no_go", 32'(busy), 0);
        press();
        check("go_start", 32'(chk_start), 1);
        check("go_rom0", 32'(rom_addr), 0);
        check("go_busy", 32'(busy), 1);
        wait_disp();
        scan_result(6, 0);
        prime_map = 16'h0000;
        press();
        check("rescan_start", 32'(chk_start), 1);
        check("rescan_rom0", 32'(rom_addr), 0);
        check("rescan_total0", 32'(prime_total), 0);
        check("rescan_disp_sel", 32'(disp_sel), 0);
        repeat (10) tick();
        go_btn = 1'b1; tick();
        go_btn = 1'b0; tick();
        go_btn = 1'b1; tick();
        go_btn = 1'b0;
        wait_disp();
        scan_result(0, 0);
        prime_map = 16'hFFFF;
        spur = 1'b1;
        press();
        wait_disp();
        scan_result(16, 0);
        spur = 1'b0;
        prime_map = 16'h0041;
        press();
        for (int i = 0; i < 500 && !(rom_addr == 4'd7 && busy && !chk_start); i++) tick();
        check("reached_wait7", 32'(rom_addr), 7);
        go_btn = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_rom_addr", 32'(rom_addr), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_total", 32'(prime_total), 0);
        check("clr_chk_start", 32'(chk_start), 0);
        repeat (4) tick();
        check("no_restart_held", 32'(busy), 0);
        go_btn = 1'b0;
        tick();
        press();
        check("repress_start", 32'(chk_start), 1);
        wait_disp();
        scan_result(2, 0);
`ifdef PRIME_TIMEOUT_EN
        hang_addr = 3;
        prime_map = 16'h000F;
        press();
        tick();
        check("err_clear_scan", 32'(err), 0);
        wait_disp();
        check("timeout_cycles", wait3, 9);
        scan_result(3, 1);
        hang_addr = -1;
        press();
        check("err_clear_go", 32'(err), 0);
        wait_disp();
        scan_result(4, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
